cam_sccb_config: RTL and testbench

CAM_SCCB_CONFIG -- requirements
Module: cam_sccb_config

---
 rtl/cam_pkg.sv | 13 +
 rtl/cam_cfg_rom.sv | 19 +
 rtl/cam_sccb_config.sv | 162 ++++++++++++++++
 tb/tb_cam_sccb_config.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera SCCB configuration block.
package cam_pkg;

  typedef enum logic [3:0] {
    IDLE, PWR, RSTW, LOAD, STRT, BIT, STOP, GAP, DONE
  } state_t;

  localparam logic [15:0] SCCB_END  = 16'hFFFF;
  localparam logic [7:0]  DEV_ID_OV = 8'h42;
  // Table capacity; LOAD stops at this index even without an end marker.
  localparam logic [7:0]  NUM_REGS  = 8'd16;

endpackage

// File: rtl/cam_cfg_rom.sv
// Register table: {addr, data} per index, one-cycle registered read.
import cam_pkg::*;

module cam_cfg_rom (
  input  logic        clk,
  input  logic [7:0]  idx,
  output logic [15:0] entry
);

  always_ff @(posedge clk) begin
    case (idx)
      8'd0:    entry <= 16'h1280;
      8'd1:    entry <= 16'h1101;
      8'd2:    entry <= 16'h6B4A;
      default: entry <= SCCB_END;
    endcase
  end

endmodule

// File: rtl/cam_sccb_config.sv
// Camera power-up sequencer and SCCB write engine driven from a ROM table.
import cam_pkg::*;

module cam_sccb_config #(
  parameter int unsigned CLK_DIV  = 60,
  parameter int unsigned PWR_WAIT = 24000,
  parameter int unsigned RST_WAIT = 480000,
  parameter int unsigned GAP_WAIT = 24000,
  parameter logic [7:0]  DEV_ID   = DEV_ID_OV
) (
  input  logic clk_24m,
  input  logic rst,
  input  logic start,
  output logic cam_pwdn,
  output logic cam_rst,
  output logic cam_soic,
  output logic soid_o,
  output logic soid_oe,
  output logic cfg_busy,
  output logic cfg_done
);

  localparam int unsigned MAX_WAIT = (PWR_WAIT > RST_WAIT) ?
    ((PWR_WAIT > GAP_WAIT) ? PWR_WAIT : GAP_WAIT) :
    ((RST_WAIT > GAP_WAIT) ? RST_WAIT : GAP_WAIT);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);

  state_t            state;
  logic [7:0]        idx;
  logic [15:0]       entry;
  logic [7:0]        addr_q, data_q, shreg;
  logic [1:0]        phase, qtr;
  logic [3:0]        bit_no;
  logic              rom_ok;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;

  cam_cfg_rom u_rom (
    .clk   (clk_24m),
    .idx   (idx),
    .entry (entry)
  );

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk_24m) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      div_cnt  <= '0;
      wait_cnt <= '0;
      cam_pwdn <= 1'b1;
      cam_rst  <= 1'b0;
      cam_soic <= 1'b1;
      soid_o   <= 1'b1;
      soid_oe  <= 1'b1;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      shreg    <= '0;
      phase    <= '0;
      qtr      <= '0;
      bit_no   <= '0;
      rom_ok   <= 1'b0;
    end else begin
      if (state inside {STRT, BIT, STOP})
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;

      case (state)
        IDLE: if (start) begin
          cam_pwdn <= 1'b0;
          cfg_busy <= 1'b1;
          wait_cnt <= '0;
          state    <= PWR;
        end
        PWR: if (wait_cnt == WAIT_W'(PWR_WAIT - 1)) begin
          cam_rst  <= 1'b1;
          wait_cnt <= '0;
          state    <= RSTW;
        end else wait_cnt <= wait_cnt + 1'b1;
        // The LOAD cycle is counted as the last cycle of the reset wait.
        RSTW: if (wait_cnt == WAIT_W'(RST_WAIT - 2)) begin
          rom_ok <= 1'b1;
          state  <= LOAD;
        end else wait_cnt <= wait_cnt + 1'b1;
        LOAD: if (!rom_ok) begin
          rom_ok <= 1'b1;
        end else if (entry == SCCB_END || idx == NUM_REGS) begin
          cfg_busy <= 1'b0;
          cfg_done <= 1'b1;
          state    <= DONE;
        end else begin
          addr_q  <= entry[15:8];
          data_q  <= entry[7:0];
          shreg   <= DEV_ID;
          soid_o  <= 1'b0;
          soid_oe <= 1'b1;
          phase   <= '0;
          bit_no  <= '0;
          qtr     <= '0;
          state   <= STRT;
        end
        STRT: if (tick) begin
          cam_soic <= 1'b0;
          state    <= BIT;
        end
        BIT: if (tick) begin
          qtr <= qtr + 1'b1;
          case (qtr)
            2'd0: if (bit_no == 4'd8) begin
              soid_oe <= 1'b0;
              soid_o  <= 1'b1;
            end else begin
              soid_oe <= 1'b1;
              soid_o  <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
            end
            2'd1, 2'd2: cam_soic <= 1'b1;
            2'd3: begin
              cam_soic <= 1'b0;
              if (bit_no == 4'd8) begin
                bit_no <= '0;
                case (phase)
                  2'd0:    begin shreg <= addr_q; phase <= 2'd1; end
                  2'd1:    begin shreg <= data_q; phase <= 2'd2; end
                  default: state <= STOP;
                endcase
              end else bit_no <= bit_no + 1'b1;
            end
          endcase
        end
        STOP: if (tick) begin
          qtr <= qtr + 1'b1;
          case (qtr)
            2'd0: begin soid_oe <= 1'b1; soid_o <= 1'b0; end
            2'd1: cam_soic <= 1'b1;
            default: begin
              soid_o   <= 1'b1;
              qtr      <= '0;
              wait_cnt <= '0;
              state    <= GAP;
            end
          endcase
        end
        GAP: if (wait_cnt == WAIT_W'(GAP_WAIT - 1)) begin
          wait_cnt <= '0;
          if (idx != 8'hFF) idx <= idx + 1'b1;
          rom_ok   <= 1'b0;
          state    <= LOAD;
        end else wait_cnt <= wait_cnt + 1'b1;
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_sccb_config.sv
// Randomized scoreboard bench: decodes SCCB writes off the pins and checks them against a table model.
module tb_cam_sccb_config;

  localparam int unsigned GAP = 4;

  logic clk, rst, start;
  logic cam_pwdn, cam_rst, cam_soic, soid_o, soid_oe, cfg_busy, cfg_done;
  logic sda_line;

  int tests = 0;
  int fails = 0;

  logic [23:0] exp_q[$];
  logic [15:0] tbl[$] = '{16'h1280, 16'h1101, 16'h6B4A, 16'hFFFF};

  // monitor state
  logic        scl_prev, sda_prev;
  logic [26:0] shv;
  int          nbits = 0;
  int          idle = 0;
  int          writes_seen = 0;
  bit          in_xfer = 0, have_stop = 0, skip = 1;

  cam_sccb_config #(
    .CLK_DIV  (2),
    .PWR_WAIT (4),
    .RST_WAIT (8),
    .GAP_WAIT (GAP),
    .DEV_ID   (8'h42)
  ) dut (
    .clk_24m  (clk),
    .rst      (rst),
    .start    (start),
    .cam_pwdn (cam_pwdn),
    .cam_rst  (cam_rst),
    .cam_soic (cam_soic),
    .soid_o   (soid_o),
    .soid_oe  (soid_oe),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done)
  );

  assign sda_line = soid_oe ? soid_o : 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: every table entry up to the end marker or capacity becomes one write.
  task automatic push_model();
    for (int i = 0; i < 16 && i < tbl.size(); i++) begin
      if (tbl[i] == 16'hFFFF) break;
      exp_q.push_back({8'h42, tbl[i]});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      in_xfer = 0; nbits = 0; have_stop = 0; skip = 1;
      exp_q.delete();
    end else if (skip) begin
      skip = 0;
    end else begin
      if (sda_line != sda_prev || cam_soic != scl_prev) begin
        check("sda_scl_same_edge", 32'((sda_line != sda_prev) && (cam_soic != scl_prev)), 32'd0);
      end
      if (scl_prev && cam_soic && sda_prev && !sda_line) begin
        check("start_while_in_xfer", 32'(in_xfer), 32'd0);
        if (have_stop) begin
          tests++;
          if (idle < int'(GAP)) begin
            fails++;
            $display("FAIL gap_idle: got %0d idle cycles, expected >= %0d", idle, GAP);
          end
        end
        in_xfer = 1; nbits = 0;
      end else if (scl_prev && cam_soic && !sda_prev && sda_line) begin
        check("stop_bit_count", 32'(nbits), 32'd27);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got %0h, expected none", {shv[26:19], shv[17:10], shv[8:1]});
        end else begin
          check("write_decode", 32'({shv[26:19], shv[17:10], shv[8:1]}), 32'(exp_q.pop_front()));
        end
        in_xfer = 0; have_stop = 1; idle = 0; writes_seen++;
      end else if (!scl_prev && cam_soic) begin
        check("scl_rise_in_xfer", 32'(in_xfer), 32'd1);
        if (in_xfer && nbits < 27) begin
          check("oe_on_bit", 32'(soid_oe), (nbits % 9 == 8) ? 32'd0 : 32'd1);
          shv = {shv[25:0], sda_line};
          nbits++;
        end
      end else if (have_stop && !in_xfer && cam_soic && sda_line) begin
        idle++;
      end
    end
    scl_prev = cam_soic;
    sda_prev = sda_line;
  end

  task automatic run_start();
    int cnt;
    push_model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("pwdn_release", 32'(cam_pwdn), 32'd0);
    check("busy_on_start", 32'(cfg_busy), 32'd1);
    cnt = 0;
    while (!cam_rst && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check("rst_release_delay", 32'(cnt), 32'd4);
    cnt = 0;
    while (sda_line && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check("first_sda_fall_delay", 32'(cnt), 32'd8);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int cnt, target, base;
    bit found;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({cam_pwdn, cam_rst, cam_soic, soid_o, soid_oe, cfg_busy, cfg_done}), 32'b1011100);
    rst = 1'b0;
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;

    run_start();
    repeat ($urandom_range(1, 40)) @(posedge clk);
    #1;
    check("busy_at_spurious_start", 32'(cfg_busy), 32'd1);
    pulse_start();

    target = 9 + int'($urandom_range(0, 7));
    found = 0; cnt = 0;
    while (!found && cnt < 3000) begin
      @(posedge clk); #1; cnt++;
      if (in_xfer && nbits == target) found = 1;
    end
    check("abort_point_reached", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_reset_outputs", 32'({cam_pwdn, cam_rst, cam_soic, soid_o, soid_oe, cfg_busy, cfg_done}), 32'b1011100);
    rst = 1'b0;
    repeat ($urandom_range(2, 6)) @(posedge clk);
    #1;

    base = writes_seen;
    run_start();
    repeat ($urandom_range(30, 500)) @(posedge clk);
    #1;
    check("busy_at_spurious_start2", 32'(cfg_busy), 32'd1);
    pulse_start();

    cnt = 0;
    while (!cfg_done && cnt < 6000) begin @(posedge clk); #1; cnt++; end
    check("done_reached", 32'(cfg_done), 32'd1);
    check("busy_clear_at_done", 32'(cfg_busy), 32'd0);
    check("writes_after_restart", 32'(writes_seen - base), 32'd3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("idle_bus_at_done", 32'({cam_soic, soid_o, soid_oe}), 32'b111);

    base = writes_seen;
    pulse_start();
    repeat (200) @(posedge clk);
    #1;
    check("no_retrigger_writes", 32'(writes_seen - base), 32'd0);
    check("done_held", 32'({cfg_done, cfg_busy, cam_pwdn, cam_rst}), 32'b1001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
